// File: rtl/fp_add_pkg.sv
// Shared constants and state encoding for the single-precision adder pipeline.
// Widths here are the defaults; blocks may override them via parameters.
package fp_add_pkg;

   localparam int MENT_WIDTH = 23;
   localparam int EXPO_WIDTH = 8;
   localparam int POS_W      = $clog2(MENT_WIDTH) + 1;

   localparam logic [EXPO_WIDTH-1:0] EXP_MAX = {EXPO_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fp_add_norm_ctrl.sv
// Iterative normalization controller: finds the left-shift for the raw mantissa
// sum one bit per cycle and produces the adjusted exponent plus status flags.
module fp_add_norm_ctrl #(
   parameter int  MENT_WIDTH = fp_add_pkg::MENT_WIDTH,
   parameter int  EXPO_WIDTH = fp_add_pkg::EXPO_WIDTH,
   localparam int POS_W      = $clog2(MENT_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [MENT_WIDTH+1:0] sum_in,
   input  logic [EXPO_WIDTH-1:0] bigger_exponent_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  valid_bit_out,
   output logic [POS_W-1:0]      normalize_position_out,
   output logic                  shift_right_out,
   output logic [EXPO_WIDTH-1:0] normalized_exponent_out,
   output logic                  zero_out,
   output logic                  underflow_out,
   output logic                  overflow_out
);

   import fp_add_pkg::*;

   localparam int XW = EXPO_WIDTH + 1;
   localparam logic [XW-1:0] EXP_TOP_X = {1'b0, {EXPO_WIDTH{1'b1}}};

   state_t                state_r;
   logic [MENT_WIDTH-1:0] work_r;
   logic [EXPO_WIDTH-1:0] exp_r;
   logic [EXPO_WIDTH-1:0] limit_r;
   logic [POS_W-1:0]      count_r;

   logic [XW-1:0]         exp_inc_s;
   logic [EXPO_WIDTH-1:0] limit_in_s;
   logic [POS_W-1:0]      count_nx_s;
   logic [EXPO_WIDTH-1:0] count_nx_e_s;
   logic [EXPO_WIDTH-1:0] exp_dec_s;
   logic                  hit_s;
   logic                  lim_s;

   // Exponent adjust, scan limit and scan-exit conditions
   always_comb begin
      exp_inc_s = {1'b0, bigger_exponent_in} + {{EXPO_WIDTH{1'b0}}, 1'b1};
      if (bigger_exponent_in == {EXPO_WIDTH{1'b0}}) begin
         limit_in_s = {EXPO_WIDTH{1'b0}};
      end else begin
         limit_in_s = bigger_exponent_in - {{(EXPO_WIDTH-1){1'b0}}, 1'b1};
      end
      count_nx_s   = count_r + {{(POS_W-1){1'b0}}, 1'b1};
      count_nx_e_s = {{(EXPO_WIDTH-POS_W){1'b0}}, count_nx_s};
      // count never exceeds limit = exp-1, so this stays >= 1
      exp_dec_s    = exp_r - count_nx_e_s;
      hit_s        = work_r[MENT_WIDTH-1];
      lim_s        = (count_nx_e_s == limit_r);
   end

   // Control FSM with all handshake, position, exponent and flag outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r                 <= IDLE;
         work_r                  <= {MENT_WIDTH{1'b0}};
         exp_r                   <= {EXPO_WIDTH{1'b0}};
         limit_r                 <= {EXPO_WIDTH{1'b0}};
         count_r                 <= {POS_W{1'b0}};
         in_ready                <= 1'b1;
         out_valid               <= 1'b0;
         valid_bit_out           <= 1'b0;
         normalize_position_out  <= {POS_W{1'b0}};
         shift_right_out         <= 1'b0;
         normalized_exponent_out <= {EXPO_WIDTH{1'b0}};
         zero_out                <= 1'b0;
         underflow_out           <= 1'b0;
         overflow_out            <= 1'b0;
      end else if (flush_in) begin
         state_r                 <= IDLE;
         work_r                  <= {MENT_WIDTH{1'b0}};
         exp_r                   <= {EXPO_WIDTH{1'b0}};
         limit_r                 <= {EXPO_WIDTH{1'b0}};
         count_r                 <= {POS_W{1'b0}};
         in_ready                <= 1'b1;
         out_valid               <= 1'b0;
         valid_bit_out           <= 1'b0;
         normalize_position_out  <= {POS_W{1'b0}};
         shift_right_out         <= 1'b0;
         normalized_exponent_out <= {EXPO_WIDTH{1'b0}};
         zero_out                <= 1'b0;
         underflow_out           <= 1'b0;
         overflow_out            <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready <= 1'b0;
                  work_r   <= sum_in[MENT_WIDTH-1:0];
                  exp_r    <= bigger_exponent_in;
                  limit_r  <= limit_in_s;
                  count_r  <= {POS_W{1'b0}};
                  normalize_position_out <= {POS_W{1'b0}};
                  if (sum_in[MENT_WIDTH+1]) begin
                     state_r                 <= DONE;
                     out_valid               <= 1'b1;
                     valid_bit_out           <= 1'b1;
                     shift_right_out         <= 1'b1;
                     normalized_exponent_out <= exp_inc_s[EXPO_WIDTH-1:0];
                     overflow_out            <= (exp_inc_s == EXP_TOP_X);
                  end else if (sum_in == {(MENT_WIDTH+2){1'b0}}) begin
                     state_r                 <= DONE;
                     out_valid               <= 1'b1;
                     valid_bit_out           <= 1'b1;
                     zero_out                <= 1'b1;
                     normalized_exponent_out <= {EXPO_WIDTH{1'b0}};
                  end else if (sum_in[MENT_WIDTH]) begin
                     state_r                 <= DONE;
                     out_valid               <= 1'b1;
                     valid_bit_out           <= 1'b1;
                     normalized_exponent_out <= bigger_exponent_in;
                  end else if (limit_in_s == {EXPO_WIDTH{1'b0}}) begin
                     state_r                 <= DONE;
                     out_valid               <= 1'b1;
                     valid_bit_out           <= 1'b1;
                     underflow_out           <= 1'b1;
                     normalized_exponent_out <= bigger_exponent_in;
                  end else begin
                     state_r <= SCAN;
                  end
               end
            end
            SCAN: begin
               work_r  <= {work_r[MENT_WIDTH-2:0], 1'b0};
               count_r <= count_nx_s;
               if (hit_s || lim_s) begin
                  state_r                 <= DONE;
                  out_valid               <= 1'b1;
                  valid_bit_out           <= 1'b1;
                  normalize_position_out  <= count_nx_s;
                  normalized_exponent_out <= exp_dec_s;
                  underflow_out           <= !hit_s;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_r                 <= IDLE;
                  in_ready                <= 1'b1;
                  out_valid               <= 1'b0;
                  valid_bit_out           <= 1'b0;
                  normalize_position_out  <= {POS_W{1'b0}};
                  shift_right_out         <= 1'b0;
                  normalized_exponent_out <= {EXPO_WIDTH{1'b0}};
                  zero_out                <= 1'b0;
                  underflow_out           <= 1'b0;
                  overflow_out            <= 1'b0;
               end
            end
            default: begin
               state_r   <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               valid_bit_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_add_norm_ctrl.sv
// Directed bench for fp_add_norm_ctrl: hand-computed vectors, backpressure,
// flush and asynchronous reset during a scan.
module tb_fp_add_norm_ctrl;

   import fp_add_pkg::*;

   localparam int MW = fp_add_pkg::MENT_WIDTH;
   localparam int EW = fp_add_pkg::EXPO_WIDTH;
   localparam int PW = fp_add_pkg::POS_W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush_in = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [MW+1:0] sum_in = '0;
   logic [EW-1:0] bigger_exponent_in = '0;
   logic          in_ready, out_valid, valid_bit_out, shift_right_out;
   logic          zero_out, underflow_out, overflow_out;
   logic [PW-1:0] normalize_position_out;
   logic [EW-1:0] normalized_exponent_out;

   int tests = 0;
   int failures = 0;

   fp_add_norm_ctrl #(.MENT_WIDTH(MW), .EXPO_WIDTH(EW)) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .flush_in                (flush_in),
      .in_valid                (in_valid),
      .in_ready                (in_ready),
      .sum_in                  (sum_in),
      .bigger_exponent_in      (bigger_exponent_in),
      .out_valid               (out_valid),
      .out_ready               (out_ready),
      .valid_bit_out           (valid_bit_out),
      .normalize_position_out  (normalize_position_out),
      .shift_right_out         (shift_right_out),
      .normalized_exponent_out (normalized_exponent_out),
      .zero_out                (zero_out),
      .underflow_out           (underflow_out),
      .overflow_out            (overflow_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " in_ready"},  32'(in_ready), 32'd1);
      check({tag, " out_valid"}, 32'(out_valid), 32'd0);
      check({tag, " valid_bit"}, 32'(valid_bit_out), 32'd0);
      check({tag, " pos"},       32'(normalize_position_out), 32'd0);
      check({tag, " exp"},       32'(normalized_exponent_out), 32'd0);
      check({tag, " flags"},     32'({shift_right_out, zero_out, underflow_out, overflow_out}), 32'd0);
   endtask

   task automatic check_done(input string tag, input int pos, input int sr, input int e,
                             input int z, input int u, input int o);
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " valid_bit"}, 32'(valid_bit_out), 32'd1);
      check({tag, " in_ready"},  32'(in_ready), 32'd0);
      check({tag, " pos"},       32'(normalize_position_out), 32'(pos));
      check({tag, " shr"},       32'(shift_right_out), 32'(sr));
      check({tag, " exp"},       32'(normalized_exponent_out), 32'(e));
      check({tag, " zero"},      32'(zero_out), 32'(z));
      check({tag, " uflow"},     32'(underflow_out), 32'(u));
      check({tag, " oflow"},     32'(overflow_out), 32'(o));
   endtask

   // Present one transaction and count edges (including the accept edge) until out_valid.
   task automatic run(input string tag, input logic [MW+1:0] s, input logic [EW-1:0] e,
                      input int lat);
      int edges;
      sum_in = s;
      bigger_exponent_in = e;
      in_valid = 1'b1;
      step();
      edges = 1;
      in_valid = 1'b0;
      while (out_valid !== 1'b1 && edges < 40) begin
         step();
         edges++;
      end
      check({tag, " latency"}, 32'(edges), 32'(lat));
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_idle({tag, " release"});
   endtask

   initial begin
      repeat (2) step();
      check_idle("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step();

      run("carry", 25'h1000000, 8'd130, 1);
      check_done("carry", 0, 1, 131, 0, 0, 0);
      release_out("carry");

      run("shift3", 25'h0100000, 8'd127, 4);
      check_done("shift3", 3, 0, 124, 0, 0, 0);
      release_out("shift3");

      run("zero", 25'h0000000, 8'd100, 1);
      check_done("zero", 0, 0, 0, 1, 0, 0);
      release_out("zero");

      run("uflow", 25'h0000001, 8'd3, 3);
      check_done("uflow", 2, 0, 1, 0, 1, 0);
      release_out("uflow");

      run("oflow", 25'h1000000, 8'd254, 1);
      check_done("oflow", 0, 1, 255, 0, 0, 1);
      release_out("oflow");

      run("hidden", 25'h0800000, 8'd50, 1);
      check_done("hidden", 0, 0, 50, 0, 0, 0);
      release_out("hidden");

      run("maxshift", 25'h0000001, 8'd200, 24);
      check_done("maxshift", 23, 0, 177, 0, 0, 0);
      release_out("maxshift");

      run("limzero", 25'h0000001, 8'd1, 1);
      check_done("limzero", 0, 0, 1, 0, 1, 0);
      release_out("limzero");

      run("hitlim", 25'h0400000, 8'd2, 2);
      check_done("hitlim", 1, 0, 1, 0, 0, 0);
      release_out("hitlim");

      // Backpressure: outputs hold while out_ready is low, new input is not taken
      run("bp", 25'h0100000, 8'd127, 4);
      sum_in = 25'h1000000;
      bigger_exponent_in = 8'd10;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check_done("bp hold", 3, 0, 124, 0, 0, 0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_idle("bp release");
      step();
      in_valid = 1'b0;
      check_done("bp next", 0, 1, 11, 0, 0, 0);
      release_out("bp next");

      // Flush in the middle of a scan
      sum_in = 25'h0000001;
      bigger_exponent_in = 8'd200;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      flush_in = 1'b1;
      step();
      flush_in = 1'b0;
      check_idle("flush");
      repeat (3) step();
      check_idle("flush settle");
      run("after flush", 25'h0100000, 8'd127, 4);
      check_done("after flush", 3, 0, 124, 0, 0, 0);
      release_out("after flush");

      // Asynchronous reset in the middle of a scan
      sum_in = 25'h0000001;
      bigger_exponent_in = 8'd200;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      check_idle("async reset");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_idle("post reset");
      run("after reset", 25'h1000000, 8'd130, 1);
      check_done("after reset", 0, 1, 131, 0, 0, 0);
      release_out("after reset");

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
